// File: rtl/muxnx_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muxnx_defs (package)
// Description : Definitions shared by the muxnx2 mux family and the ping-pong
//               buffer that feeds it: default word width and the occupancy
//               state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package muxnx_defs;

    // Default data word width, common to muxnx2 and its upstream buffer.
    localparam int MUXNX_M = 16;

    // Occupancy states; the encoding equals the number of buffered words.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/regnx1_en.sv
`default_nettype none
// ============================================================================
// Module      : regnx1_en
// Description : M-bit register with synchronous active-high reset and load
//               enable.
//   clk  : clock
//   rst  : synchronous active-high reset (clears q)
//   i_en : load enable
//   i_d  : data in (M bits)
//   o_q  : registered data out (M bits)
// Revision    : 1.0 - initial release
// ============================================================================
module regnx1_en #(
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [M-1:0] i_d,
    output logic [M-1:0] o_q
);

    logic [M-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pingpong_bufnx2.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_bufnx2
// Description : Two-bank ping-pong buffer feeding the muxnx2 2:1 word mux.
//               Words are written alternately into bank 0 / bank 1; the read
//               pointer drives the mux select so the mux output is always the
//               oldest unread word.
//   clk / rst       : clock, synchronous active-high reset
//   flush           : synchronous discard of all buffered words (data kept)
//   in_data/valid   : producer word and handshake; in_ready back-pressure
//   bank0 / bank1   : bank contents, to muxnx2 I0 / I1
//   sel             : read pointer, to muxnx2 sel
//   out_valid/ready : consumer handshake for the selected word
//   count           : occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_bufnx2
    import muxnx_defs::*;
#(
    parameter int M = MUXNX_M
) (
    input  logic         pingpong_bufnx2_port_clk,
    input  logic         pingpong_bufnx2_port_rst,
    input  logic         pingpong_bufnx2_port_flush,
    input  logic [M-1:0] pingpong_bufnx2_port_in_data,
    input  logic         pingpong_bufnx2_port_in_valid,
    output logic         pingpong_bufnx2_port_in_ready,
    output logic [M-1:0] pingpong_bufnx2_port_bank0,
    output logic [M-1:0] pingpong_bufnx2_port_bank1,
    output logic         pingpong_bufnx2_port_sel,
    output logic         pingpong_bufnx2_port_out_valid,
    input  logic         pingpong_bufnx2_port_out_ready,
    output logic [1:0]   pingpong_bufnx2_port_count
);

    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_full;
    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_wr;
    logic         w_rd;
    logic [M-1:0] w_bank [2];

    // in_ready depends only on registered state: a pop while FULL does not
    // open a slot for a same-cycle push.
    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = r_full[r_rd_ptr];

    // Flush drops any handshake in the same cycle.
    assign w_wr = pingpong_bufnx2_port_in_valid & w_in_ready & ~pingpong_bufnx2_port_flush;
    assign w_rd = w_out_valid & pingpong_bufnx2_port_out_ready & ~pingpong_bufnx2_port_flush;

    // Pointer and flag bookkeeping.
    always_ff @(posedge pingpong_bufnx2_port_clk) begin
        if (pingpong_bufnx2_port_rst || pingpong_bufnx2_port_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_full   <= 2'b00;
        end else begin
            if (w_wr) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            // Write and read never target the same bank in one cycle: a write
            // only happens below FULL, where wr_ptr points at an empty bank.
            if (w_rd) begin
                r_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= ~r_rd_ptr;
            end
        end
    end

    // Occupancy state register.
    always_ff @(posedge pingpong_bufnx2_port_clk) begin
        if (pingpong_bufnx2_port_rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next-state.
    always_comb begin
        w_state_nxt = r_state;
        if (pingpong_bufnx2_port_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_wr)          w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_wr && !w_rd)       w_state_nxt = ST_FULL;
                    else if (!w_wr && w_rd)  w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_rd)          w_state_nxt = ST_ONE;
                default:                     w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // One storage register per bank; loaded only when the write pointer
    // selects it.
    for (genvar i = 0; i < 2; i++) begin : g_bank
        regnx1_en #(.M(M)) u_bank (
            .clk  (pingpong_bufnx2_port_clk),
            .rst  (pingpong_bufnx2_port_rst),
            .i_en (w_wr && (r_wr_ptr == 1'(i))),
            .i_d  (pingpong_bufnx2_port_in_data),
            .o_q  (w_bank[i])
        );
    end

    assign pingpong_bufnx2_port_in_ready  = w_in_ready;
    assign pingpong_bufnx2_port_out_valid = w_out_valid;
    assign pingpong_bufnx2_port_sel       = r_rd_ptr;
    assign pingpong_bufnx2_port_bank0     = w_bank[0];
    assign pingpong_bufnx2_port_bank1     = w_bank[1];
    assign pingpong_bufnx2_port_count     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_bufnx2.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_bufnx2
// Description : Directed self-checking bench for pingpong_bufnx2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_bufnx2;

    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [M-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] bank0;
    logic [M-1:0] bank1;
    logic         sel;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   count;
    logic [M-1:0] mux_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behaviour of the downstream muxnx2.
    assign mux_out = sel ? bank1 : bank0;

    pingpong_bufnx2 #(.M(M)) dut (
        .pingpong_bufnx2_port_clk       (clk),
        .pingpong_bufnx2_port_rst       (rst),
        .pingpong_bufnx2_port_flush     (flush),
        .pingpong_bufnx2_port_in_data   (in_data),
        .pingpong_bufnx2_port_in_valid  (in_valid),
        .pingpong_bufnx2_port_in_ready  (in_ready),
        .pingpong_bufnx2_port_bank0     (bank0),
        .pingpong_bufnx2_port_bank1     (bank1),
        .pingpong_bufnx2_port_sel       (sel),
        .pingpong_bufnx2_port_out_valid (out_valid),
        .pingpong_bufnx2_port_out_ready (out_ready),
        .pingpong_bufnx2_port_count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [M-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        set_in(1'b1, 16'hFFFF, 1'b0);
        step(); step();
        check("rst_count",  32'(count),     32'd0);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_iready", 32'(in_ready),  32'd1);
        check("rst_sel",    32'(sel),       32'd0);
        check("rst_bank0",  32'(bank0),     32'h0000);
        check("rst_bank1",  32'(bank1),     32'h0000);

        // Fill
        rst = 1'b0;
        set_in(1'b1, 16'hA5A5, 1'b0); step();
        check("fill1_count", 32'(count),     32'd1);
        check("fill1_bank0", 32'(bank0),     32'hA5A5);
        check("fill1_ovld",  32'(out_valid), 32'd1);
        set_in(1'b1, 16'h5A5A, 1'b0); step();
        check("fill2_count", 32'(count),    32'd2);
        check("fill2_bank1", 32'(bank1),    32'h5A5A);
        check("fill2_irdy",  32'(in_ready), 32'd0);
        check("fill2_sel",   32'(sel),      32'd0);
        set_in(1'b1, 16'h1234, 1'b0); step();
        check("fill3_count", 32'(count), 32'd2);
        check("fill3_bank0", 32'(bank0), 32'hA5A5);
        check("fill3_bank1", 32'(bank1), 32'h5A5A);

        // Drain order
        set_in(1'b0, 16'h0000, 1'b1);
        check("drain_mux0", 32'(mux_out), 32'hA5A5);
        step();
        check("drain1_sel",   32'(sel),     32'd1);
        check("drain1_count", 32'(count),   32'd1);
        check("drain1_mux",   32'(mux_out), 32'h5A5A);
        step();
        check("drain2_sel",   32'(sel),       32'd0);
        check("drain2_count", 32'(count),     32'd0);
        check("drain2_ovld",  32'(out_valid), 32'd0);

        // Simultaneous read and write in ONE
        set_in(1'b1, 16'h0001, 1'b0); step();
        check("sim_pre_bank0", 32'(bank0), 32'h0001);
        set_in(1'b1, 16'h0002, 1'b1); step();
        check("sim_count", 32'(count),     32'd1);
        check("sim_sel",   32'(sel),       32'd1);
        check("sim_bank1", 32'(bank1),     32'h0002);
        check("sim_ovld",  32'(out_valid), 32'd1);

        // Backpressure: FULL, read and write offered together
        set_in(1'b1, 16'h0003, 1'b0); step();
        check("bp_pre_count", 32'(count), 32'd2);
        check("bp_pre_bank0", 32'(bank0), 32'h0003);
        set_in(1'b1, 16'h0004, 1'b1); step();
        check("bp_count", 32'(count),     32'd1);
        check("bp_sel",   32'(sel),       32'd0);
        check("bp_bank1", 32'(bank1),     32'h0002);
        check("bp_bank0", 32'(bank0),     32'h0003);
        check("bp_ovld",  32'(out_valid), 32'd1);

        // Flush from FULL with a write and read offered
        set_in(1'b1, 16'h0005, 1'b0); step();
        check("fl_pre_count", 32'(count), 32'd2);
        flush = 1'b1;
        set_in(1'b1, 16'h9999, 1'b1); step();
        flush = 1'b0;
        check("fl_count", 32'(count),     32'd0);
        check("fl_sel",   32'(sel),       32'd0);
        check("fl_ovld",  32'(out_valid), 32'd0);
        check("fl_irdy",  32'(in_ready),  32'd1);
        check("fl_bank0", 32'(bank0),     32'h0003);
        check("fl_bank1", 32'(bank1),     32'h0005);
        set_in(1'b1, 16'hBEEF, 1'b0); step();
        check("fl_wr_bank0", 32'(bank0),     32'hBEEF);
        check("fl_wr_bank1", 32'(bank1),     32'h0005);
        check("fl_wr_count", 32'(count),     32'd1);
        check("fl_wr_ovld",  32'(out_valid), 32'd1);

        // Reset mid-operation
        rst = 1'b1;
        set_in(1'b1, 16'h7777, 1'b1); step();
        rst = 1'b0;
        set_in(1'b0, 16'h0000, 1'b0);
        check("mrst_count", 32'(count),     32'd0);
        check("mrst_ovld",  32'(out_valid), 32'd0);
        check("mrst_bank0", 32'(bank0),     32'h0000);
        check("mrst_bank1", 32'(bank1),     32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pingpong_bufnx2.md
Name: pingpong_bufnx2

Overview:
- Two-bank ping-pong buffer that sits directly upstream of the 2:1 word mux, muxnx2.
- Accepts M-bit words over a valid/ready handshake and writes them alternately into bank 0 and bank 1.
- Drives both banks and the read-bank select straight into the mux's I0/I1/sel inputs.
- The mux output is therefore always the oldest unread word; the consumer pops it via out_valid/out_ready.

Parameters:
- M, 16, data word width (matches muxnx2 M).

Ports:
- pingpong_bufnx2_port_clk  input  1  clock; all state updates on rising edge.
- pingpong_bufnx2_port_rst  input  1  synchronous, active-high reset.
- pingpong_bufnx2_port_flush  input  1  synchronous discard of all buffered words.
- pingpong_bufnx2_port_in_data  input  M  write word.
- pingpong_bufnx2_port_in_valid  input  1  producer offers in_data.
- pingpong_bufnx2_port_in_ready  output  1  buffer can accept a word this cycle.
- pingpong_bufnx2_port_bank0  output  M  bank 0 contents; to muxnx2 I0.
- pingpong_bufnx2_port_bank1  output  M  bank 1 contents; to muxnx2 I1.
- pingpong_bufnx2_port_sel  output  1  read pointer; to muxnx2 sel.
- pingpong_bufnx2_port_out_valid  output  1  word at selected bank is unread.
- pingpong_bufnx2_port_out_ready  input  1  consumer takes selected word.
- pingpong_bufnx2_port_count  output  2  occupancy, 0..2.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: bank0=0, bank1=0, wr_ptr=0, rd_ptr=0 (sel=0), full[1:0]=00, count=0, out_valid=0, in_ready=1.
- State machine, derived from count:
  - EMPTY (0): in_ready=1, out_valid=0.
  - ONE (1): in_ready=1, out_valid=1.
  - FULL (2): in_ready=0, out_valid=1.
- in_ready is a registered-state function only (count<2). It has no combinational path from out_ready, so a read in FULL does not allow a same-cycle write.
- out_valid = full[rd_ptr].
- Write: when in_valid & in_ready, bank[wr_ptr] <= in_data, full[wr_ptr] <= 1, wr_ptr toggles.
- in_valid while in_ready=0 is ignored; no state change.
- Read: when out_valid & out_ready, full[rd_ptr] <= 0 and rd_ptr toggles. Bank contents are NOT cleared on read.
- out_ready while out_valid=0 is ignored.
- Transitions:
  - EMPTY -> ONE on write.
  - ONE -> FULL on write without read.
  - ONE -> EMPTY on read without write.
  - ONE -> ONE on simultaneous write and read; the new word goes to the other bank and sel toggles.
  - FULL -> ONE on read.
- Latency: a word accepted at edge N appears on bankX and raises out_valid after edge N. Fall-through latency is 1 cycle; there is no bypass.
- Stability: while out_valid=1 and out_ready=0, sel and the selected bank hold constant.
- Pointers are 1 bit and wrap 1->0 naturally.
- Flush: synchronous. Sets full=00, wr_ptr=0, rd_ptr=0, count=0. Bank data is retained. Flush has priority over a same-cycle write or read; both are dropped.
- Reset mid-operation: reset has priority over everything. Pending words are lost and outputs return to reset values on the next edge.

Decomposition:
- Shared package/include muxnx_defs holds:
  - the state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - the default width constant 16, shared with muxnx2.
- Sub-module regnx1_en: M-bit register with synchronous active-high reset and load enable. Instantiated twice in a generate loop, one per bank, with enable = write & (wr_ptr==i).
- Pointer, flag and count logic stays in the top.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_data=16'hFFFF -> count=0, out_valid=0, in_ready=1, sel=0, bank0=bank1=16'h0000.
- Fill: write 16'hA5A5 then 16'h5A5A with out_ready=0 -> bank0=A5A5, bank1=5A5A, count=2, in_ready=0, sel=0. A third write of 16'h1234 is ignored.
- Drain order: from FULL, hold out_ready=1 for 2 cycles -> sel 0->1->0, count 2->1->0; mux output reads A5A5 then 5A5A; out_valid drops after the second pop.
- Simultaneous: in ONE holding 16'h0001 in bank0, write 16'h0002 with out_ready=1 -> count stays 1, sel=1, bank1=0002, out_valid=1.
- Backpressure: FULL with out_ready=1 and in_valid=1 in the same cycle -> read occurs, write is refused (in_ready was 0), count=1.
- Flush: in FULL, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, sel=0, out_valid=0, banks unchanged. A subsequent write of 16'hBEEF lands in bank0.
